// File: rtl/mar_seq.sv
// Memory address register with direct load and a strided address sequencer.
// Sequence addresses are offered to the memory controller over a valid/ready handshake.
module mar_seq #(
  parameter int AW     = 8,
  parameter int LW     = 8,
  parameter int STRIDE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wmar,
  input  logic [AW-1:0] mar_in,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] count,
  input  logic          dir,
  input  logic          abort,
  input  logic          addr_ready,
  output logic [AW-1:0] mar_out,
  output logic          addr_valid,
  output logic          busy,
  output logic          done,
  output logic          wrapped
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    RUN      = 1'b1;
  localparam logic [AW:0]   STRIDE_W = (AW+1)'(STRIDE);
  localparam logic [LW-1:0] ZERO_L   = LW'(0);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  logic [0:0]    state_r, state_s;
  logic [AW-1:0] mar_r, mar_s;
  logic [LW-1:0] rem_r, rem_s;
  logic          dir_r, dir_s;
  logic          wrapped_r, wrapped_s;
  logic          done_r, done_s;
  logic [AW:0]   step_s;

  // Next sequence address; the extra top bit flags a carry out or borrow across the boundary.
  always_comb begin
    step_s = {1'b0, mar_r};
    if (dir_r) begin
      step_s = {1'b0, mar_r} - STRIDE_W;
    end else begin
      step_s = {1'b0, mar_r} + STRIDE_W;
    end
  end

  // Next-state logic for the sequencer and the register contents.
  always_comb begin
    state_s   = state_r;
    mar_s     = mar_r;
    rem_s     = rem_r;
    dir_s     = dir_r;
    wrapped_s = wrapped_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mar_s     = base;
          wrapped_s = 1'b0;
          if (count != ZERO_L) begin
            rem_s   = count;
            dir_s   = dir;
            state_s = RUN;
          end else begin
            done_s  = 1'b1;
          end
        end else if (wmar) begin
          mar_s     = mar_in;
          wrapped_s = 1'b0;
        end else begin
          mar_s     = mar_r;
        end
      end
      RUN: begin
        // Abort wins over a same-cycle handshake and never produces a done pulse.
        if (abort) begin
          state_s = IDLE;
          rem_s   = ZERO_L;
        end else if (addr_ready) begin
          if (rem_r == ONE_L) begin
            state_s = IDLE;
            rem_s   = ZERO_L;
            done_s  = 1'b1;
          end else begin
            rem_s = rem_r - ONE_L;
            mar_s = step_s[AW-1:0];
            if (step_s[AW]) begin
              wrapped_s = 1'b1;
            end else begin
              wrapped_s = wrapped_r;
            end
          end
        end else begin
          rem_s = rem_r;
        end
      end
      default: begin
        state_s = IDLE;
        rem_s   = ZERO_L;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      mar_r     <= '0;
      rem_r     <= ZERO_L;
      dir_r     <= 1'b0;
      wrapped_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      mar_r     <= mar_s;
      rem_r     <= rem_s;
      dir_r     <= dir_s;
      wrapped_r <= wrapped_s;
      done_r    <= done_s;
    end
  end

  assign mar_out    = mar_r;
  assign addr_valid = state_r[0];
  assign busy       = state_r[0];
  assign done       = done_r;
  assign wrapped    = wrapped_r;

endmodule

// File: tb/tb_mar_seq.sv
// Scoreboard bench for mar_seq: stimulus queues expected addresses and done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mar_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wmar = 1'b0;
  logic [7:0] mar_in = 8'h00;
  logic       start = 1'b0;
  logic [7:0] base = 8'h00;
  logic [7:0] count = 8'h00;
  logic       dir = 1'b0;
  logic       abort = 1'b0;
  logic       addr_ready = 1'b1;
  logic [7:0] mar_out;
  logic       addr_valid, busy, done, wrapped;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {wrapped, address} per handshake
  logic [7:0] done_q[$];  // mar_out expected at each done pulse

  mar_seq #(.AW(8), .LW(8), .STRIDE(1)) dut (
    .clk(clk), .reset(reset), .wmar(wmar), .mar_in(mar_in), .start(start),
    .base(base), .count(count), .dir(dir), .abort(abort), .addr_ready(addr_ready),
    .mar_out(mar_out), .addr_valid(addr_valid), .busy(busy), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compare every presented-and-accepted address and every done pulse.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      if (addr_valid && addr_ready) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_addr");
        end else begin
          e = exp_q.pop_front();
          chk("addr", 32'(mar_out), 32'(e[7:0]));
          chk("wrapped", 32'(wrapped), 32'(e[8]));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          chk("done_addr", 32'(mar_out), 32'(done_q.pop_front()));
          chk("done_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic start_seq(input logic [7:0] b, input logic [7:0] c, input logic d);
    @(posedge clk); #1;
    start = 1'b1; base = b; count = c; dir = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("timeout_wait_idle");
  endtask

  initial begin
    #2;
    chk("rst_mar", 32'(mar_out), 32'h00);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    #11 reset = 1'b1;

    // Ascending, no wrap
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h12});
    done_q.push_back(8'h12);
    start_seq(8'h10, 8'd3, 1'b0);
    wait_idle();
    chk("asc_hold_mar", 32'(mar_out), 32'h12);
    chk("asc_wrapped", 32'(wrapped), 32'd0);

    // Ascending across 0xFF -> 0x00
    exp_q.push_back({1'b0, 8'hFE}); exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h01});
    done_q.push_back(8'h01);
    start_seq(8'hFE, 8'd4, 1'b0);
    wait_idle();

    // Descending across 0x00 -> 0xFF
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b1, 8'hFF});
    done_q.push_back(8'hFF);
    start_seq(8'h01, 8'd3, 1'b1);
    wait_idle();
    chk("desc_wrapped_sticky", 32'(wrapped), 32'd1);

    // Direct load clears wrapped
    @(posedge clk); #1;
    wmar = 1'b1; mar_in = 8'hA5;
    @(posedge clk); #1;
    wmar = 1'b0;
    chk("wmar_mar", 32'(mar_out), 32'hA5);
    chk("wmar_wrapped", 32'(wrapped), 32'd0);
    chk("wmar_busy", 32'(busy), 32'd0);

    // Back-pressure: first address held for three valid cycles
    addr_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h40}); exp_q.push_back({1'b0, 8'h41});
    done_q.push_back(8'h41);
    start_seq(8'h40, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_mar", 32'(mar_out), 32'h40);
      chk("stall_valid", 32'(addr_valid), 32'd1);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    addr_ready = 1'b1;
    wait_idle();

    // Abort on the second address
    exp_q.push_back({1'b0, 8'h20}); exp_q.push_back({1'b0, 8'h21});
    start_seq(8'h20, 8'd5, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(addr_valid), 32'd0);
    chk("abort_mar", 32'(mar_out), 32'h21);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done), 32'd0);

    // Zero-count start: immediate done, stays idle
    done_q.push_back(8'h33);
    start_seq(8'h33, 8'd0, 1'b0);
    chk("cnt0_mar", 32'(mar_out), 32'h33);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("cnt0_done_pulse", 32'(done), 32'd0);

    // start and wmar together: base wins
    done_q.push_back(8'h55);
    @(posedge clk); #1;
    start = 1'b1; wmar = 1'b1; base = 8'h55; mar_in = 8'h99; count = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; wmar = 1'b0;
    chk("start_wins", 32'(mar_out), 32'h55);

    // Asynchronous reset mid-sequence
    exp_q.push_back({1'b0, 8'h60});
    start_seq(8'h60, 8'd5, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_mar", 32'(mar_out), 32'h00);
    chk("arst_valid", 32'(addr_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    exp_q.push_back({1'b0, 8'h70});
    done_q.push_back(8'h70);
    start_seq(8'h70, 8'd1, 1'b0);
    chk("post_rst_run", 32'(busy), 32'd1);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("addr_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mar_seq.md
Name: mar_seq

Overview:
Parametrised memory address register for the data-memory path, the next generation of the plain load-only MAR. It keeps the direct-load path (wmar/mar_in) and adds an address sequencer. The sequencer is given a base address and an element count. It then walks addresses up or down by a fixed stride, presenting each one with a valid/ready handshake to the memory controller. It sits between the control unit and the data-memory address input.

Parameters:
AW, 8, address width in bits (mar_out, mar_in, base).
LW, 8, width of count and internal remaining-element counter.
STRIDE, 1, address step per accepted address; must be less than 2^AW.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
wmar  input  1  direct load strobe (legacy MAR behaviour).
mar_in  input  AW  direct load value.
start  input  1  begin a sequence; sampled on the clock edge.
base  input  AW  first address of the sequence.
count  input  LW  number of addresses to issue.
dir  input  1  0 = ascending, 1 = descending; latched at start.
abort  input  1  terminate a running sequence.
addr_ready  input  1  consumer accepts the current address.
mar_out  output  AW  current address register.
addr_valid  output  1  mar_out is a sequence address awaiting acceptance.
busy  output  1  sequencer in RUN.
done  output  1  one-cycle pulse at normal sequence completion.
wrapped  output  1  sticky flag: the sequence crossed the 0 / 2^AW-1 boundary.

Behaviour:
- Reset (reset=0, asynchronous; outputs change without waiting for clk): mar_out=0, addr_valid=0, busy=0, done=0, wrapped=0, remaining=0, state=IDLE.
- States: IDLE, RUN. addr_valid = busy = (state==RUN), both registered.
- done defaults to 0 every cycle. It is 1 only for the single cycle stated below.
- IDLE, start=1, count!=0: next cycle mar_out=base, remaining=count, dir latched, wrapped=0, state=RUN.
- IDLE, start=1, count==0: next cycle mar_out=base, wrapped=0, done=1, state stays IDLE.
- IDLE, wmar=1, start=0: next cycle mar_out=mar_in, wrapped=0. Latency is 1 cycle, as in the legacy MAR.
- start and wmar together in IDLE: start wins.
- RUN, handshake (addr_valid & addr_ready):
  - remaining==1: next cycle state=IDLE and done=1. mar_out holds the last issued address.
  - otherwise: remaining-1, and mar_out steps by STRIDE, increasing if dir=0, decreasing if dir=1. Arithmetic is modulo 2^AW.
  - If a step overflows or underflows, wrapped is set to 1 and stays 1 until the next start, wmar or reset.
- RUN, no handshake: mar_out, remaining and addr_valid hold. An address is never dropped or changed while valid and unaccepted.
- RUN, abort=1: takes priority over a same-cycle handshake. Next cycle state=IDLE, no done pulse, mar_out holds, remaining cleared.
- start and wmar are ignored in RUN.
- Throughput: one address per cycle while addr_ready=1. The first address is valid on the cycle after start.
- Reset asserted mid-sequence: all outputs go to their reset values immediately; no done pulse.

Test Plan:
- AW=8, start, base=0x10, count=3, dir=0, ready=1 -> mar_out 0x10,0x11,0x12 on 3 consecutive valid cycles; done=1 the cycle after the 3rd handshake; mar_out stays 0x12; wrapped=0.
- base=0xFE, count=4, dir=0 -> 0xFE,0xFF,0x00,0x01; wrapped=1 from the cycle showing 0x00. Descending case: base=0x01, count=3, dir=1 -> 0x01,0x00,0xFF; wrapped=1.
- base=0x40, count=2, addr_ready low for 2 cycles on the first address -> 0x40 held with addr_valid=1 for 3 cycles, then 0x41, then done.
- base=0x20, count=5, abort on the 2nd address with ready=1 -> IDLE next cycle, mar_out=0x21, done never pulses, busy=0.
- IDLE wmar=1, mar_in=0xA5 -> mar_out=0xA5 next cycle. start with count=0, base=0x33 -> mar_out=0x33, done pulse, busy stays 0. start and wmar together -> base loaded.
- reset driven low mid-sequence between clock edges -> mar_out=0, addr_valid=0, busy=0 immediately; after release, the sequencer is idle and accepts a new start.
